// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared integer-datapath definitions for the write-back stage
//                and its neighbours (forwarding unit, register file).
//                XLEN   - datapath width
//                NREG   - architectural integer registers (x0 hard-wired to 0)
//                AW     - register index width, log2(NREG)
//                REG_ZERO - index of the hard-wired zero register
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mux
//  Description : Write-back result select and commit-qualifier generation.
//                Shared with the forwarding unit so both see exactly the same
//                notion of "this WB slot writes a register this cycle".
//  Ports       : i_memtoreg_wb  1: select load data, 0: select ALU result
//                i_regwrite_wb  write enable of the WB slot
//                i_wb_stall     hold; suppresses the write
//                i_rd_wb        destination register index
//                i_mem_data_w   load data
//                i_alu_out      ALU result
//                o_wb_result    selected write-back value
//                o_wb_valid     slot commits this cycle (never for x0)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_mux
    import cpu_pkg::*;
(
    input  logic           i_memtoreg_wb,
    input  logic           i_regwrite_wb,
    input  logic           i_wb_stall,
    input  logic [AW-1:0]  i_rd_wb,
    input  logic [XLEN-1:0] i_mem_data_w,
    input  logic [XLEN-1:0] i_alu_out,
    output logic [XLEN-1:0] o_wb_result,
    output logic            o_wb_valid
);

    always_comb begin
        o_wb_result = i_memtoreg_wb ? i_mem_data_w : i_alu_out;
        // Stall wins over regwrite; x0 writes are dropped here so that
        // neither the register file nor forwarding ever treats them as real.
        o_wb_valid  = i_regwrite_wb & ~i_wb_stall & (i_rd_wb != REG_ZERO);
    end

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Write-back end of the MEM/WB interface. Selects the result,
//                commits it to the integer register file and serves two
//                combinational ID-stage read ports with write-through bypass.
//                Also keeps a 64-bit retired-write counter and a registered
//                debug read port (no bypass on the debug port).
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                memtoreg_wb, regwrite_wb WB-slot controls
//                mem_data_W, alu_out      WB-slot data
//                rd_wb                    destination index
//                wb_stall                 hold the WB slot
//                rs1_addr/rs1_data        read port 1 (combinational)
//                rs2_addr/rs2_data        read port 2 (combinational)
//                wb_result, wb_valid      muxed result / commit qualifier
//                dbg_addr/dbg_data        debug read (1-cycle latency)
//                retire_cnt               committed-write counter
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            memtoreg_wb,
    input  logic            regwrite_wb,
    input  logic [XLEN-1:0] mem_data_W,
    input  logic [XLEN-1:0] alu_out,
    input  logic [AW-1:0]   rd_wb,
    input  logic            wb_stall,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_result,
    output logic            wb_valid,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [63:0]     retire_cnt
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] r_dbg_data;
    logic [63:0]     r_retire_cnt;

    logic [XLEN-1:0] w_wb_result;
    logic            w_wb_valid;

    wb_mux u_wb_mux (
        .i_memtoreg_wb (memtoreg_wb),
        .i_regwrite_wb (regwrite_wb),
        .i_wb_stall    (wb_stall),
        .i_rd_wb       (rd_wb),
        .i_mem_data_w  (mem_data_W),
        .i_alu_out     (alu_out),
        .o_wb_result   (w_wb_result),
        .o_wb_valid    (w_wb_valid)
    );

    // ------------------------------------------------------------------------
    // Storage and commit. Entry 0 is cleared on reset and never written
    // (w_wb_valid excludes x0), so it stays zero; reads still gate it
    // explicitly so x0 cannot be disturbed by anything upstream.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_valid) begin
            r_regs[rd_wb] <= w_wb_result;
        end
    end

    // ------------------------------------------------------------------------
    // Retired-write counter; wraps silently at 2^64.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_wb_valid) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Debug port samples the array before this cycle's commit lands, so a
    // same-cycle write to the probed register shows up one cycle later.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_data <= '0;
        end else if (dbg_addr == REG_ZERO) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_regs[dbg_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Read ports with write-through bypass. Bypass is driven only by the
    // combinational commit qualifier, so it remains active during reset.
    // ------------------------------------------------------------------------
    always_comb begin
        rs1_data = r_regs[rs1_addr];
        if (rs1_addr == REG_ZERO) begin
            rs1_data = '0;
        end else if (w_wb_valid && (rd_wb == rs1_addr)) begin
            rs1_data = w_wb_result;
        end
    end

    always_comb begin
        rs2_data = r_regs[rs2_addr];
        if (rs2_addr == REG_ZERO) begin
            rs2_data = '0;
        end else if (w_wb_valid && (rd_wb == rs2_addr)) begin
            rs2_data = w_wb_result;
        end
    end

    assign wb_result  = w_wb_result;
    assign wb_valid   = w_wb_valid;
    assign dbg_data   = r_dbg_data;
    assign retire_cnt = r_retire_cnt;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_regfile
//  Description : Self-checking bench for wb_regfile. A table of WB-slot and
//                read-port vectors carries the expected combinational
//                outputs; a small register/counter model predicts the
//                registered debug data and retire count, which are queued
//                when a vector is driven and compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;
    import cpu_pkg::*;

    logic            clk;
    logic            rst;
    logic            memtoreg_wb;
    logic            regwrite_wb;
    logic [XLEN-1:0] mem_data_W;
    logic [XLEN-1:0] alu_out;
    logic [AW-1:0]   rd_wb;
    logic            wb_stall;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] wb_result;
    logic            wb_valid;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic [63:0]     retire_cnt;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .memtoreg_wb (memtoreg_wb),
        .regwrite_wb (regwrite_wb),
        .mem_data_W  (mem_data_W),
        .alu_out     (alu_out),
        .rd_wb       (rd_wb),
        .wb_stall    (wb_stall),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_result   (wb_result),
        .wb_valid    (wb_valid),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .retire_cnt  (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            mtr;
        logic            rw;
        logic            st;
        logic [AW-1:0]   rd;
        logic [AW-1:0]   a1;
        logic [AW-1:0]   a2;
        logic [AW-1:0]   da;
        logic [XLEN-1:0] md;
        logic [XLEN-1:0] ao;
        logic [XLEN-1:0] e_rs1;
        logic [XLEN-1:0] e_rs2;
        logic [XLEN-1:0] e_res;
        logic            e_valid;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] dbg;
        logic [63:0]     cnt;
    } exp_t;

    localparam logic [63:0] BEEF = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] LD   = 64'h0000_0000_0000_1234;
    localparam logic [63:0] A5   = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] HI   = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    vec_t            vecs [17];
    exp_t            sb_q [$];
    logic [XLEN-1:0] m_reg [NREG];
    logic [63:0]     m_cnt;
    int              n_cmp;
    int              n_bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic run_vec(input int idx);
        vec_t v;
        exp_t e;
        exp_t got;
        logic commit;
        v           = vecs[idx];
        rst         = v.rst;
        memtoreg_wb = v.mtr;
        regwrite_wb = v.rw;
        wb_stall    = v.st;
        rd_wb       = v.rd;
        rs1_addr    = v.a1;
        rs2_addr    = v.a2;
        dbg_addr    = v.da;
        mem_data_W  = v.md;
        alu_out     = v.ao;
        #1;
        chk($sformatf("v%0d rs1_data", idx), rs1_data, v.e_rs1);
        chk($sformatf("v%0d rs2_data", idx), rs2_data, v.e_rs2);
        chk($sformatf("v%0d wb_result", idx), wb_result, v.e_res);
        chk($sformatf("v%0d wb_valid", idx), {63'd0, wb_valid}, {63'd0, v.e_valid});

        // Model: debug reads the pre-commit array; reset wins over everything.
        commit = v.rw && !v.st && (v.rd != 5'd0);
        if (v.rst) begin
            e.dbg = '0;
            e.cnt = '0;
            for (int i = 0; i < NREG; i++) m_reg[i] = '0;
            m_cnt = '0;
        end else begin
            e.dbg = (v.da == 5'd0) ? 64'd0 : m_reg[v.da];
            if (commit) begin
                m_reg[v.rd] = v.mtr ? v.md : v.ao;
                m_cnt       = m_cnt + 64'd1;
            end
            e.cnt = m_cnt;
        end
        sb_q.push_back(e);

        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("scoreboard empty", 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            chk($sformatf("v%0d dbg_data", idx), dbg_data, got.dbg);
            chk($sformatf("v%0d retire_cnt", idx), retire_cnt, got.cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_cnt = '0;
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;

        //            rst mtr rw st rd  a1  a2  da  md      ao     e_rs1 e_rs2 e_res e_valid
        // Commit presented during reset: bypass visible, state discarded.
        vecs[0]  = '{1'b1,1'b0,1'b1,1'b0,5'd5, 5'd5, 5'd0, 5'd0, 64'd0,   64'h55, 64'h55, 64'd0, 64'h55, 1'b1};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,5'd0, 5'd5, 5'd0, 5'd5, 64'd0,   64'd0,  64'd0,  64'd0, 64'd0,  1'b0};
        // ALU commit to x5 (load data present but unselected).
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,5'd5, 5'd1, 5'd2, 5'd0, 64'h1111,BEEF,   64'd0,  64'd0, BEEF,   1'b1};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,5'd0, 5'd5, 5'd0, 5'd5, 64'd0,   64'd0,  BEEF,   64'd0, 64'd0,  1'b0};
        // Load commit to x7 with both read ports bypassing; debug sees old value.
        vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,5'd7, 5'd7, 5'd7, 5'd7, LD,      64'h9999,LD,    LD,    LD,     1'b1};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,5'd0, 5'd7, 5'd5, 5'd7, 64'd0,   64'd0,  LD,     BEEF,  64'd0,  1'b0};
        // x0 write dropped.
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 5'd0, 64'd0,   ONES,   64'd0,  64'd0, ONES,   1'b0};
        // Stall holds the slot: no bypass, no commit; then released.
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,5'd3, 5'd3, 5'd3, 5'd3, 64'd0,   64'd9,  64'd0,  64'd0, 64'd9,  1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,5'd3, 5'd3, 5'd5, 5'd3, 64'd0,   64'd9,  64'd9,  BEEF,  64'd9,  1'b1};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,5'd0, 5'd3, 5'd7, 5'd3, 64'd0,   64'd0,  64'd9,  LD,    64'd0,  1'b0};
        // Overwrite x5 from load data; top register x31.
        vecs[10] = '{1'b0,1'b1,1'b1,1'b0,5'd5, 5'd5, 5'd3, 5'd5, A5,      64'h77, A5,     64'd9, A5,     1'b1};
        vecs[11] = '{1'b0,1'b0,1'b1,1'b0,5'd31,5'd31,5'd31,5'd31,64'h88,  HI,     HI,     HI,    HI,     1'b1};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,5'd0, 5'd31,5'd5, 5'd31,64'd0,   64'd0,  HI,     A5,    64'd0,  1'b0};
        // Reset after writes: state still visible this cycle, bypass still active.
        vecs[13] = '{1'b1,1'b0,1'b1,1'b0,5'd9, 5'd31,5'd9, 5'd31,64'd0,   64'd7,  HI,     64'd7, 64'd7,  1'b1};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0,5'd0, 5'd31,5'd9, 5'd5, 64'd0,   64'd0,  64'd0,  64'd0, 64'd0,  1'b0};
        // Counter wrap sequence.
        vecs[15] = '{1'b0,1'b0,1'b1,1'b0,5'd2, 5'd2, 5'd0, 5'd0, 64'd0,   64'd1,  64'd1,  64'd0, 64'd1,  1'b1};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b0,5'd0, 5'd2, 5'd0, 5'd2, 64'd0,   64'd0,  64'd1,  64'd0, 64'd0,  1'b0};

        rst         = 1'b1;
        memtoreg_wb = 1'b0;
        regwrite_wb = 1'b0;
        wb_stall    = 1'b0;
        rd_wb       = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        dbg_addr    = '0;
        mem_data_W  = '0;
        alu_out     = '0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) run_vec(i);

        // Preload the counter to its maximum and let one commit wrap it.
        force dut.r_retire_cnt = ONES;
        release dut.r_retire_cnt;
        m_cnt = ONES;
        #1;
        chk("preload retire_cnt", retire_cnt, ONES);
        @(negedge clk);
        run_vec(15);
        run_vec(16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire
